f_pc_unit: RTL and testbench

//  Fetch-side PC generator for the 5-stage MIPS pipeline: owns the F-stage PC register and computes the next PC.

---
 rtl/f_pc_unit_pkg.sv | 32 +++
 rtl/f_pc_unit_d_cmp.sv | 26 ++
 rtl/f_pc_unit.sv | 85 ++++++++
 tb/tb_f_pc_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/f_pc_unit_pkg.sv
// Shared definitions for the fetch-side PC generator: next-PC selector codes,
// branch compare codes, default vectors and the branch-target helper.
package f_pc_unit_pkg;

    typedef enum logic [2:0] {
        NPC_PC4     = 3'd0,
        NPC_B       = 3'd1,
        NPC_J_JAL   = 3'd2,
        NPC_JR_JALR = 3'd3
    } npc_op_e;

    typedef enum logic [2:0] {
        CMP_BEQ  = 3'd0,
        CMP_BNE  = 3'd1,
        CMP_BLEZ = 3'd2,
        CMP_BGTZ = 3'd3,
        CMP_BLTZ = 3'd4,
        CMP_BGEZ = 3'd5
    } cmp_op_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] DEF_IMEM_LO    = 32'h0000_3000;
    localparam logic [31:0] DEF_IMEM_HI    = 32'h0000_6FFC;

    // Branch target relative to the branch's own delay slot (D_PC+4).
    function automatic logic [31:0] branch_target(input logic [31:0] d_pc,
                                                  input logic [15:0] offset);
        return d_pc + 32'd4 + {{14{offset[15]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/f_pc_unit_d_cmp.sv
// Branch condition evaluator: signed/equality compare of the forwarded
// register values selected by the compare opcode. Purely combinational.
module d_cmp
    import f_pc_unit_pkg::*;
(
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [2:0]  CmpOp,
    output logic        cond
);

    // Evaluate the selected compare; unknown opcodes never branch.
    always_comb begin
        cond = 1'b0;
        case (CmpOp)
            CMP_BEQ:  cond = (rs == rt);
            CMP_BNE:  cond = (rs != rt);
            CMP_BLEZ: cond = ($signed(rs) <= 32'sd0);
            CMP_BGTZ: cond = ($signed(rs) >  32'sd0);
            CMP_BLTZ: cond = rs[31];
            CMP_BGEZ: cond = ~rs[31];
            default:  cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch-side PC generator: F-stage PC register plus next-PC selection
// (exception, eret, branch, jump, register jump, sequential).
// Optional feature macro: PC_ADDR_CHECK_EN enables the fetch address-error flag.
module f_pc_unit
    import f_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter bit          ERET_ADD4  = 1'b1,
    parameter logic [31:0] IMEM_LO    = DEF_IMEM_LO,
    parameter logic [31:0] IMEM_HI    = DEF_IMEM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Req,
    input  logic        eret,
    input  logic [31:0] EPC,
    input  logic [2:0]  NPCOp,
    input  logic [2:0]  CmpOp,
    input  logic [31:0] D_PC,
    input  logic [25:0] imm26,
    input  logic [15:0] imm16,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] F_PC,
    output logic [31:0] NPC,
    output logic        b_jump,
    output logic [31:0] D_LinkAddr,
    output logic        F_DelaySlot,
    output logic        F_ExcAdEL
);

    logic        cmp_true;
    logic [31:0] pc_plus4;
    logic [31:0] eret_target;

    d_cmp u_cmp (
        .rs    (rs),
        .rt    (rt),
        .CmpOp (CmpOp),
        .cond  (cmp_true)
    );

    assign b_jump      = cmp_true & (NPCOp == NPC_B);
    assign pc_plus4    = F_PC + 32'd4;
    assign eret_target = ERET_ADD4 ? (EPC + 32'd4) : EPC;
    assign D_LinkAddr  = D_PC + 32'd8;
    assign F_DelaySlot = (NPCOp != NPC_PC4) & ~Req & ~eret;

    // Next-PC priority: exception request, then eret, then the decoder's selector.
    always_comb begin
        NPC = pc_plus4;
        if (Req) begin
            NPC = EXC_VECTOR;
        end else if (eret) begin
            NPC = eret_target;
        end else begin
            case (NPCOp)
                NPC_B:       NPC = b_jump ? branch_target(D_PC, imm16) : pc_plus4;
                NPC_J_JAL:   NPC = {D_PC[31:28], imm26, 2'b00};
                NPC_JR_JALR: NPC = rs;
                default:     NPC = pc_plus4;
            endcase
        end
    end

    // PC register: redirects from Req/eret go through even when the pipe is stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            F_PC <= RESET_PC;
        end else if (Req | eret | ~stall) begin
            F_PC <= NPC;
        end
    end

`ifdef PC_ADDR_CHECK_EN
    assign F_ExcAdEL = reset & ((F_PC[1:0] != 2'b00) | (F_PC < IMEM_LO) | (F_PC > IMEM_HI));
`else
    logic unused_imem_bounds;
    assign unused_imem_bounds = ^{IMEM_LO, IMEM_HI};
    assign F_ExcAdEL = 1'b0;
`endif

endmodule

// File: tb/tb_f_pc_unit.sv
// Randomised scoreboard bench for f_pc_unit: directed scenarios followed by
// random traffic, expected values from a plain-arithmetic reference model.
module tb_f_pc_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;
    localparam logic [31:0] LO      = 32'h0000_3000;
    localparam logic [31:0] HI      = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, Req, eret;
    logic [31:0] EPC, D_PC, rs, rt;
    logic [2:0]  NPCOp, CmpOp;
    logic [25:0] imm26;
    logic [15:0] imm16;
    logic [31:0] F_PC, NPC, D_LinkAddr;
    logic        b_jump, F_DelaySlot, F_ExcAdEL;

    typedef struct packed {
        logic        rst_n;
        logic        st;
        logic        rq;
        logic        er;
        logic [2:0]  nop;
        logic [2:0]  cop;
        logic [31:0] dpc;
        logic [25:0] i26;
        logic [15:0] i16;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] epc;
    } stim_t;

    typedef struct {
        logic [31:0] f_pc;
        logic [31:0] npc;
        logic [31:0] link;
        logic        bj;
        logic        ds;
        logic        adel;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_pc = RST_PC;
    int          checks_total  = 0;
    int          checks_passed = 0;

    f_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .Req         (Req),
        .eret        (eret),
        .EPC         (EPC),
        .NPCOp       (NPCOp),
        .CmpOp       (CmpOp),
        .D_PC        (D_PC),
        .imm26       (imm26),
        .imm16       (imm16),
        .rs          (rs),
        .rt          (rt),
        .F_PC        (F_PC),
        .NPC         (NPC),
        .b_jump      (b_jump),
        .D_LinkAddr  (D_LinkAddr),
        .F_DelaySlot (F_DelaySlot),
        .F_ExcAdEL   (F_ExcAdEL)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Branch rule from the ISA: signed 32-bit comparisons, equality for beq/bne.
    function automatic bit ref_cond(input logic [2:0] cop, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        sa = longint'($signed(a));
        case (cop)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return sa <= 0;
            3'd3:    return sa > 0;
            3'd4:    return sa < 0;
            3'd5:    return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] wrap32(input longint v);
        return 32'(v & 64'h0000_0000_FFFF_FFFF);
    endfunction

    // Reference outputs for one cycle given the current model PC.
    function automatic exp_t ref_model(input stim_t s, input logic [31:0] pc);
        exp_t   e;
        longint seq;
        seq    = longint'(pc) + 4;
        e.f_pc = pc;
        e.bj   = (s.nop == 3'd1) && ref_cond(s.cop, s.rsv, s.rtv);
        e.link = wrap32(longint'(s.dpc) + 8);
        e.ds   = (s.nop != 3'd0) && !s.rq && !s.er;
        if (s.rq)
            e.npc = EXC_VEC;
        else if (s.er)
            e.npc = wrap32(longint'(s.epc) + 4);
        else if (s.nop == 3'd1)
            e.npc = e.bj ? wrap32(longint'(s.dpc) + 4 + longint'($signed(s.i16)) * 4) : wrap32(seq);
        else if (s.nop == 3'd2)
            e.npc = (s.dpc & 32'hF000_0000) | (32'(s.i26) * 4);
        else if (s.nop == 3'd3)
            e.npc = s.rsv;
        else
            e.npc = wrap32(seq);
`ifdef PC_ADDR_CHECK_EN
        e.adel = s.rst_n && ((pc % 4 != 0) || (pc < LO) || (pc > HI));
`else
        e.adel = 1'b0;
`endif
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        s.dpc   = 32'h0000_3000;
        return s;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the expected response.
    task automatic apply_stimulus(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset = s.rst_n; stall = s.st; Req = s.rq; eret = s.er;
        NPCOp = s.nop; CmpOp = s.cop; D_PC = s.dpc; imm26 = s.i26;
        imm16 = s.i16; rs = s.rsv; rt = s.rtv; EPC = s.epc;
        if (!s.rst_n) model_pc = RST_PC;
        e = ref_model(s, model_pc);
        sb_q.push_back(e);
        if (s.rst_n && (s.rq || s.er || !s.st)) model_pc = e.npc;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            checks_passed++;
    endtask

    task automatic check_output(input exp_t e);
        check_val("F_PC",        F_PC,        e.f_pc);
        check_val("NPC",         NPC,         e.npc);
        check_val("b_jump",      {31'b0, b_jump},      {31'b0, e.bj});
        check_val("D_LinkAddr",  D_LinkAddr,  e.link);
        check_val("F_DelaySlot", {31'b0, F_DelaySlot}, {31'b0, e.ds});
        check_val("F_ExcAdEL",   {31'b0, F_ExcAdEL},   {31'b0, e.adel});
    endtask

    // Monitor: whenever the driver has queued an expectation, compare settled outputs.
    always begin
        @(negedge clk);
        #2;
        while (sb_q.size() > 0) check_output(sb_q.pop_front());
    end

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        stim_t s;
        reset = 1'b0; stall = 1'b0; Req = 1'b0; eret = 1'b0;
        NPCOp = '0; CmpOp = '0; D_PC = '0; imm26 = '0; imm16 = '0;
        rs = '0; rt = '0; EPC = '0;

        // Reset held, then sequential fetch after release.
        s = idle(); s.rst_n = 1'b0;
        apply_stimulus(s);
        apply_stimulus(s);
        s = idle();
        repeat (4) apply_stimulus(s);

        // beq taken backward, then not taken.
        s = idle(); s.nop = 3'd1; s.cop = 3'd0; s.dpc = 32'h0000_3010;
        s.i16 = 16'hFFFC; s.rsv = 32'd5; s.rtv = 32'd5;
        apply_stimulus(s);
        s.rtv = 32'd6;
        apply_stimulus(s);

        // Signed compares on the most negative value and zero.
        for (int c = 2; c <= 5; c++) begin
            s = idle(); s.nop = 3'd1; s.cop = 3'(c); s.st = 1'b1;
            s.dpc = 32'h0000_3100; s.i16 = 16'h0010; s.rsv = 32'h8000_0000;
            apply_stimulus(s);
            s.rsv = 32'h0;
            apply_stimulus(s);
        end

        // Jump to 0x3020, stall two cycles, Req overrides stall.
        s = idle(); s.nop = 3'd3; s.rsv = 32'h0000_3020;
        apply_stimulus(s);
        s = idle(); s.st = 1'b1;
        apply_stimulus(s);
        apply_stimulus(s);
        s.rq = 1'b1;
        apply_stimulus(s);

        // eret return, then Req and eret together.
        s = idle(); s.er = 1'b1; s.epc = 32'h0000_3040;
        apply_stimulus(s);
        s.rq = 1'b1;
        apply_stimulus(s);

        // Address wrap and a j-format jump.
        s = idle(); s.nop = 3'd3; s.rsv = 32'hFFFF_FFFC;
        apply_stimulus(s);
        s = idle();
        apply_stimulus(s);
        s = idle(); s.nop = 3'd2; s.dpc = 32'hA000_1234; s.i26 = 26'h000_0C40;
        apply_stimulus(s);
        s = idle(); s.nop = 3'd3; s.rsv = 32'h0000_3002;
        apply_stimulus(s);
        s = idle(); s.nop = 3'd3; s.rsv = 32'h0000_7000;
        apply_stimulus(s);
        s = idle(); s.nop = 3'd3; s.rsv = 32'h0000_3004;
        apply_stimulus(s);
        s = idle();
        apply_stimulus(s);

        // Random traffic, including undefined selector and compare codes.
        for (int i = 0; i < 400; i++) begin
            int sel;
            s     = idle();
            sel   = $urandom_range(0, 9);
            s.nop = (sel < 4 || sel == 9) ? 3'd0 : (sel < 6) ? 3'd1 : (sel == 6) ? 3'd2 :
                    (sel == 7) ? 3'd3 : 3'($urandom_range(4, 7));
            s.cop = 3'($urandom_range(0, 7));
            s.dpc = model_pc - 32'd4;
            s.i26 = 26'($urandom);
            s.i16 = 16'($urandom);
            s.rsv = pick_val();
            s.rtv = ($urandom_range(0, 2) == 0) ? s.rsv : pick_val();
            if (s.nop == 3'd3 && $urandom_range(0, 3) != 0)
                s.rsv = 32'h0000_3000 + 32'($urandom_range(0, 16'h1000)) * 4;
            s.epc = 32'h0000_3000 + 32'($urandom_range(0, 255)) * 4;
            s.st  = ($urandom_range(0, 4) == 0);
            s.rq  = ($urandom_range(0, 19) == 0);
            s.er  = ($urandom_range(0, 14) == 0);
            if (i == 200) s.rst_n = 1'b0;
            apply_stimulus(s);
        end

        s = idle();
        apply_stimulus(s);
        repeat (2) @(negedge clk);
        #4;
        check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
